// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types, scan-code constants and default timing
// for the receiver and the downstream keyboard matrix decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  localparam int DEF_FILTER_LEN  = 8;
  localparam int DEF_TIMEOUT_CYC = 14000;
  localparam int DEF_FIFO_AW     = 3;

  // Odd parity over data plus parity bit
  function automatic logic odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_scan_rx_if.sv
// Host-side scan-code bundle between the PS/2 receiver and the
// keyboard matrix decoder.
interface ps2_scan_rx_if #(
  parameter int AW = 3
) ();

  logic [7:0]  rx_scan_code;
  logic        rx_data_ready;
  logic        rx_read;
  logic        rx_err_parity;
  logic        rx_err_frame;
  logic        rx_overflow;
  logic [AW:0] rx_level;

  modport master (
    output rx_scan_code,
    output rx_data_ready,
    output rx_err_parity,
    output rx_err_frame,
    output rx_overflow,
    output rx_level,
    input  rx_read
  );

  modport slave (
    input  rx_scan_code,
    input  rx_data_ready,
    input  rx_err_parity,
    input  rx_err_frame,
    input  rx_overflow,
    input  rx_level,
    output rx_read
  );

endinterface

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO with registered pop output; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module ps2_rx_fifo #(
  parameter int AW = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= 8'h00;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: line sync, clock glitch filter,
// frame FSM with timeout, and scan-code FIFO.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FIFO_AW     = DEF_FIFO_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  ps2_scan_rx_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]      clk_s;
  logic [1:0]      dat_s;
  logic            clk_f;
  logic            clk_f_q;
  logic [FW-1:0]   fcnt;
  logic            fall;
  logic            d;

  rx_state_t       state;
  rx_state_t       nxt;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            par_ok;
  logic [TW-1:0]   tcnt;
  logic            tmo;

  logic            push_d;
  logic            perr_d;
  logic            ferr_d;
  logic            push_q;
  logic            perr_q;
  logic            ferr_q;
  logic            ovf_q;

  logic [FIFO_AW:0] level;
  logic             full;
  logic             empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_i};
      dat_s <= {dat_s[0], ps2_data_i};
    end
  end

  assign d = dat_s[1];

  // clk_f follows the line only after FILTER_LEN differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
      fcnt    <= '0;
    end else begin
      clk_f_q <= clk_f;
      if (clk_s[1] == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fcnt  <= '0;
        clk_f <= clk_s[1];
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign fall = clk_f_q & ~clk_f;

  assign tmo = (state != IDLE) && !fall &&
               (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (tmo) begin
      nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!d) nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) nxt = PARITY;
        PARITY:  nxt = STOP;
        STOP:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // Parity failure wins over a bad stop bit
  always_comb begin
    push_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    if (fall && state == STOP) begin
      if (!par_ok)
        perr_d = 1'b1;
      else if (!d)
        ferr_d = 1'b1;
      else
        push_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 8'h00;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      tcnt    <= '0;
      push_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      push_q <= push_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q  <= push_q && full && !(bus.rx_read && !empty);
      if (fall)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC - 1))
        tcnt <= tcnt + TW'(1);
      if (tmo) begin
        shreg <= 8'h00;
      end else if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {d, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_ok <= odd_ok(shreg, d);
          default: ;
        endcase
      end
    end
  end

  ps2_rx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_q),
    .din     (shreg),
    .pop     (bus.rx_read),
    .dout    (bus.rx_scan_code),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign bus.rx_data_ready = !empty;
  assign bus.rx_level      = level;
  assign bus.rx_err_parity = perr_q;
  assign bus.rx_err_frame  = ferr_q | tmo;
  assign bus.rx_overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: vector table, corner-case sequences and
// randomized frames checked against a byte-queue model.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int FL = 8;
  localparam int TO = 14000;
  localparam int AW = 3;
  localparam int H  = 30;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic ps2_clk_i  = 1'b1;
  logic ps2_data_i = 1'b1;

  ps2_scan_rx_if #(.AW(AW)) bus ();

  ps2_scan_rx #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO),
    .FIFO_AW     (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .bus        (bus)
  );

  always #35 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     n_perr = 0;
  int     n_ferr = 0;
  int     n_ovf  = 0;
  longint cyc    = 0;
  longint last_fall = 0;

  logic [7:0] q[$];
  logic [7:0] last_code = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_err_parity) n_perr++;
    if (bus.rx_err_frame)  n_ferr++;
    if (bus.rx_overflow)   n_ovf++;
  end

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    int         e_perr;
    int         e_ferr;
    int         e_push;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act,
                           input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                           input logic bp,
                                           input logic bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n,
                           input int glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data_i = bits[i];
      if (i == glitch) begin
        repeat (H / 2) @(negedge clk);
        ps2_clk_i = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk_i = 1'b1;
        repeat (H / 2 - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk_i = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic bp,
                           input logic bs, input int glitch,
                           output int dp, output int df,
                           output int dov);
    int p0, f0, o0;
    p0 = n_perr;
    f0 = n_ferr;
    o0 = n_ovf;
    send_bits(mk_frame(b, bp, bs), 11, glitch);
    repeat (20) @(negedge clk);
    dp  = n_perr - p0;
    df  = n_ferr - f0;
    dov = n_ovf - o0;
  endtask

  task automatic frame_model(input string tag, input logic [7:0] b,
                             input logic bp, input logic bs,
                             input int glitch);
    int dp, df, dov, ep, ef, eo;
    ep = 0;
    ef = 0;
    eo = 0;
    run_frame(b, bp, bs, glitch, dp, df, dov);
    if (bp)
      ep = 1;
    else if (bs)
      ef = 1;
    else if (q.size() == 2 ** AW)
      eo = 1;
    else
      q.push_back(b);
    check({tag, " perr"}, dp, ep);
    check({tag, " ferr"}, df, ef);
    check({tag, " ovf"}, dov, eo);
    check({tag, " level"}, bus.rx_level, q.size());
    check({tag, " ready"}, bus.rx_data_ready, q.size() != 0);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    exp = last_code;
    if (q.size() > 0) exp = q.pop_front();
    bus.rx_read = 1'b1;
    @(negedge clk);
    bus.rx_read = 1'b0;
    check({tag, " code"}, bus.rx_scan_code, exp);
    check({tag, " level"}, bus.rx_level, q.size());
    last_code = exp;
  endtask

  initial begin
    int dp, df, dov;
    longint seen;
    int f0;
    logic [7:0] seq[9];

    bus.rx_read = 1'b0;
    repeat (3) @(negedge clk);
    check("rst code", bus.rx_scan_code, 8'h00);
    check("rst ready", bus.rx_data_ready, 0);
    check("rst level", bus.rx_level, 0);
    check("rst errs", bus.rx_err_parity | bus.rx_err_frame |
          bus.rx_overflow, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    tbl[0] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1};
    tbl[1] = '{8'h1C, 1'b1, 1'b0, 1, 0, 0};
    tbl[2] = '{8'h29, 1'b0, 1'b1, 0, 1, 0};
    tbl[3] = '{8'h29, 1'b0, 1'b0, 0, 0, 1};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, -1,
                dp, df, dov);
      check($sformatf("vec%0d perr", i), dp, tbl[i].e_perr);
      check($sformatf("vec%0d ferr", i), df, tbl[i].e_ferr);
      check($sformatf("vec%0d ovf", i), dov, 0);
      check($sformatf("vec%0d level", i), bus.rx_level,
            tbl[i].e_push);
      check($sformatf("vec%0d ready", i), bus.rx_data_ready,
            tbl[i].e_push);
      if (tbl[i].e_push != 0) begin
        q.push_back(tbl[i].b);
        pop_check($sformatf("vec%0d pop", i));
        check($sformatf("vec%0d ready0", i), bus.rx_data_ready, 0);
      end else begin
        check($sformatf("vec%0d held", i), bus.rx_scan_code,
              last_code);
      end
    end

    f0 = n_ferr;
    seen = -1;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5, -1);
    for (int i = 0; i < TO + 200 && seen < 0; i++) begin
      @(negedge clk);
      if (bus.rx_err_frame) seen = cyc - last_fall;
    end
    check_rng("timeout lat", seen, TO + FL + 1, TO + FL + 3);
    repeat (20) @(negedge clk);
    check("timeout ferr", n_ferr - f0, 1);
    check("timeout level", bus.rx_level, 0);
    frame_model("to F0", PS2_BREAK, 1'b0, 1'b0, -1);
    frame_model("to 1C", 8'h1C, 1'b0, 1'b0, -1);
    pop_check("to pop0");
    pop_check("to pop1");

    seq = '{PS2_EXT, 8'h12, PS2_BREAK, 8'h1C, 8'h29,
            8'h5A, 8'h66, 8'h76, 8'h0D};
    for (int i = 0; i < 9; i++)
      frame_model($sformatf("ovf%0d", i), seq[i], 1'b0, 1'b0, -1);
    bus.rx_read = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("burst%0d", i), bus.rx_scan_code,
            seq[i < 8 ? i : 7]);
    end
    bus.rx_read = 1'b0;
    q.delete();
    last_code = seq[7];
    check("burst ready", bus.rx_data_ready, 0);
    check("burst level", bus.rx_level, 0);

    frame_model("glitch", 8'h5A, 1'b0, 1'b0, 4);
    pop_check("glitch pop");

    frame_model("pre 12", 8'h12, 1'b0, 1'b0, -1);
    frame_model("pre 66", 8'h66, 1'b0, 1'b0, -1);
    f0 = n_ferr + n_perr + n_ovf;
    send_bits(mk_frame(8'h76, 1'b0, 1'b0), 4, -1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid rst code", bus.rx_scan_code, 8'h00);
    check("mid rst ready", bus.rx_data_ready, 0);
    check("mid rst level", bus.rx_level, 0);
    reset_n = 1'b1;
    q.delete();
    last_code = 8'h00;
    repeat (50) @(negedge clk);
    check("mid rst errs", n_ferr + n_perr + n_ovf - f0, 0);
    frame_model("post rst", 8'h76, 1'b0, 1'b0, -1);
    pop_check("post rst pop");

    for (int i = 0; i < 24; i++) begin
      int r;
      r = $urandom_range(0, 5);
      frame_model($sformatf("rnd%0d", i), 8'($urandom),
                  r == 0, r == 1, -1);
      if ($urandom_range(0, 2) == 0)
        pop_check($sformatf("rnd%0d pop", i));
    end
    while (q.size() > 0)
      pop_check("drain");
    pop_check("empty pop");
    check("final ready", bus.rx_data_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
PS/2 device-to-host receiver that turns the raw ps2_clk/ps2_data line pair into validated 8-bit scan codes, buffered in a small FIFO. It sits directly upstream of the ZX keyboard matrix decoder, which polls rx_data_ready, pulses rx_read, and samples rx_scan_code on the following cycles. The decoder's F0/E0 prefix handling relies on bytes arriving in order, with no loss and no duplicates, which this block guarantees.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clk changes level.
TIMEOUT_CYC, 14000, clk cycles without a falling edge before a partial frame is abandoned (1 ms at 14 MHz).
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8.

Ports:
clk  in  1  system clock (14 MHz nominal).
reset_n  in  1  asynchronous, active-low reset.
ps2_clk_i  in  1  PS/2 clock line, asynchronous.
ps2_data_i  in  1  PS/2 data line, asynchronous.
rx_scan_code  out  8  byte from the most recent accepted pop; held until the next pop.
rx_data_ready  out  1  high while the FIFO is non-empty.
rx_read  in  1  pop request.
rx_err_parity  out  1  one-cycle pulse: frame dropped for bad parity.
rx_err_frame  out  1  one-cycle pulse: bad stop bit, or timeout.
rx_overflow  out  1  one-cycle pulse: valid byte dropped because the FIFO was full.
rx_level  out  FIFO_AW+1  FIFO occupancy.

Behaviour:
- Clock and reset: single clk domain. Reset is asynchronous, active-low, on reset_n.
- Reset values: rx_scan_code=8'h00, rx_data_ready=0, all error pulses 0, rx_level=0. Synchronizer and filter registers reset to 1 (idle bus). FSM resets to IDLE.
- Synchronization: both lines pass through a 2-FF synchronizer.
- Filter: filtered clock clk_f takes the synced level only after FILTER_LEN consecutive equal samples. Shorter glitches are ignored.
- Falling edge: fall = clk_f previous 1, now 0. The data bit is the synced ps2_data in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on fall cycles only, apart from timeout.
  - IDLE: fall with data=0 -> DATA, bit_cnt=0. Fall with data=1 is ignored, no error.
  - DATA: shreg <= {d, shreg[7:1]} (LSB first). bit_cnt increments. After the 8th bit -> PARITY.
  - PARITY: capture p. par_ok = ^{shreg,p} == 1 (odd parity). -> STOP.
  - STOP: d=1 and par_ok: push shreg. par_ok=0: rx_err_parity pulse. d=0 and par_ok: rx_err_frame pulse. Parity error takes precedence if both are wrong. -> IDLE.
- Error and push timing: error pulse or push happens in the cycle after the stop-bit fall.
- Timeout:
  - Counter clears on every fall and saturates.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYC-1 produces an rx_err_frame pulse, discards shreg and returns to IDLE.
  - In IDLE the counter has no effect.
- FIFO pop semantics (non-show-ahead):
  - rx_read=1 with FIFO non-empty: rx_scan_code <= head at that edge, so it is valid the next cycle. The read pointer advances.
  - rx_read with FIFO empty is ignored; rx_scan_code is unchanged.
  - rx_read held for N cycles pops up to N entries.
- rx_data_ready: equals !empty, derived from registered pointers. It reflects a push one cycle after the push edge.
- Full FIFO:
  - Push without pop: byte dropped, rx_overflow pulse, contents unchanged.
  - Push and pop in the same cycle: both succeed and rx_level is unchanged.
- Simultaneous push and pop when empty: the pop is ignored. The pushed byte appears on rx_data_ready the next cycle.
- Pointers: wrap modulo depth. rx_level = wr_ptr - rd_ptr, using FIFO_AW+1-bit pointers.
- Latency: stop-bit edge on the pin -> rx_data_ready high in 2 (sync) + FILTER_LEN + 2 cycles, ±1.
- Reset mid-frame: the partial frame is lost, the FIFO is emptied and no error pulse is generated.
- Host-to-device transmission is not supported. The block never drives the lines.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - the constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0 and PS2_BAT_OK=8'hAA, shared with the matrix decoder;
  - the default timing values.
- One natural sub-module, ps2_rx_fifo: a synchronous FIFO with push/pop, registered pop output, and level/full/empty outputs.
- Sync, filter and FSM stay in the top level.

Test Plan:
1. Valid frame 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, PS/2 clock at 12.5 kHz. Expect rx_data_ready=1. Pulse rx_read for one cycle; the next cycle shows rx_scan_code=8'h1C, rx_data_ready=0, rx_level=0.
2. Frame 0x1C with parity 1. Expect one rx_err_parity pulse, rx_level stays 0, rx_scan_code unchanged.
3. Frame 0x29 with stop bit 0. Expect one rx_err_frame pulse and no push. Then a valid 0x29 frame is accepted.
4. Timeout: send start plus 4 bits, hold the clock high for 1.5 ms. Expect rx_err_frame exactly TIMEOUT_CYC cycles after the last fall. Then frames F0 then 1C pop in order as F0, 1C.
5. Overflow: send 9 frames (E0,12,F0,1C,29,5A,66,76,0D) with no reads. Expect rx_overflow on the 9th and rx_level=8. Eight pops return E0…76 in order; 0D is absent.
6. Robustness:
   - A 3-cycle low glitch on ps2_clk_i mid-frame causes no bit shift and the frame still decodes to 0x5A.
   - reset_n pulsed low mid-frame with 2 bytes queued: all outputs return to reset values, and the next frame decodes correctly.
